// File: rtl/cpu_player_pkg.sv
// Shared types and sizing helpers for the computer-controlled player.
package cpu_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Width of the saturating press counter.
  localparam int CNT_W = 8;

  // Hold-off counter width: enough to hold HOLDOFF_CYCLES, never below 1 bit.
  function automatic int hold_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cpu_player_if.sv
// Game-side bundle for cpu_player: control/level/LFSR in, press pulse out.
// press_count exists only when CPU_PLAYER_COUNT_EN is defined.
interface cpu_player_if
  import cpu_player_pkg::*;
#(
  parameter int WIDTH = 10
);
  logic             enable;
  logic             freeze;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] lfsr;
  logic             press;
`ifdef CPU_PLAYER_COUNT_EN
  logic [CNT_W-1:0] press_count;

  modport master (output enable, freeze, level, lfsr, input press, press_count);
  modport slave  (input enable, freeze, level, lfsr, output press, press_count);
`else
  modport master (output enable, freeze, level, lfsr, input press);
  modport slave  (input enable, freeze, level, lfsr, output press);
`endif
endinterface

// File: rtl/cpu_player.sv
// Computer player: fires a one-cycle press when level > lfsr, then waits
// HOLDOFF_CYCLES idle cycles before it may fire again. freeze forces IDLE.
// Optional saturating press counter under CPU_PLAYER_COUNT_EN.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int HOLDOFF_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  cpu_player_if.slave  bus
);

  localparam int            HW        = hold_w(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  logic [WIDTH-1:0] level, lfsr;
  logic             fire;
  state_e           state_q, state_d;
  logic [HW-1:0]    cnt_q, cnt_d;
  logic             press_q, press_d;

  assign level = bus.level;
  assign lfsr  = bus.lfsr;

  // Strict unsigned compare; freeze overrides a same-cycle fire.
  assign fire = bus.enable && !bus.freeze && (level > lfsr);

  // Next-state and hold-off counter; freeze aborts from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.freeze) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (fire) state_d = PRESS;
        PRESS: begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
        HOLD: begin
          cnt_d = cnt_q - HW'(1);
          if (cnt_q <= HW'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // press is a flop mirroring state==PRESS, so no input reaches it combinationally.
  assign press_d = (state_d == PRESS);

`ifdef CPU_PLAYER_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Count completed PRESS cycles, sticking at all-ones; freeze does not clear.
  always_comb begin
    count_d = count_q;
    if (state_q == PRESS && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
  end

  assign bus.press_count = count_q;
`endif

  // FSM, hold-off counter, registered press and optional press counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
`ifdef CPU_PLAYER_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
`ifdef CPU_PLAYER_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  assign bus.press = press_q;

endmodule

// File: tb/tb_cpu_player.sv
// Directed bench for cpu_player: instance A uses HOLDOFF_CYCLES=3, instance B
// uses HOLDOFF_CYCLES=0; both see the same inputs. Inputs change and outputs
// are sampled on the falling edge.
module tb_cpu_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1, frz = 1'b0;
  logic [9:0] lvl = 10'd1023, lf = 10'd0;
  int         n_chk = 0, n_pass = 0;
  int         cnt_a, cnt_b;

  always #5 clk = ~clk;

  cpu_player_if #(.WIDTH(10)) ifa ();
  cpu_player_if #(.WIDTH(10)) ifb ();

  assign ifa.enable = en;  assign ifb.enable = en;
  assign ifa.freeze = frz; assign ifb.freeze = frz;
  assign ifa.level  = lvl; assign ifb.level  = lvl;
  assign ifa.lfsr   = lf;  assign ifb.lfsr   = lf;

  cpu_player #(.WIDTH(10), .HOLDOFF_CYCLES(3)) u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  cpu_player #(.WIDTH(10), .HOLDOFF_CYCLES(0)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #3;
    chk("reset_press_a", ifa.press, 0);
    chk("reset_press_b", ifb.press, 0);
`ifdef CPU_PLAYER_COUNT_EN
    chk("reset_count_b", ifb.press_count, 0);
`endif
    step(); step();
    reset = 1'b0;

    // Always-fire: A presses at 1,6,11,16; B presses every other cycle
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("spacing_a_c%0d", k), ifa.press, (k % 5 == 1) ? 1 : 0);
      if (k <= 8) chk($sformatf("spacing_b_c%0d", k), ifb.press, (k % 2 == 1) ? 1 : 0);
    end

    // level=0 never fires across the lfsr sweep
    lvl = 10'd0;
    for (int k = 0; k < 6; k++) step();
    cnt_a = 0; cnt_b = 0;
    for (int v = 0; v < 1023; v++) begin
      lf = 10'(v);
      step();
      cnt_a += int'(ifa.press); cnt_b += int'(ifb.press);
    end
    chk("level0_sweep_a", cnt_a, 0);
    chk("level0_sweep_b", cnt_b, 0);

    // Equality does not fire; one below fires with latency 1
    lvl = 10'd100; lf = 10'd100;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      cnt_a += int'(ifa.press); cnt_b += int'(ifb.press);
    end
    chk("equal_no_fire_a", cnt_a, 0);
    chk("equal_no_fire_b", cnt_b, 0);
    lf = 10'd99;
    step();
    chk("below_fire_a", ifa.press, 1);
    chk("below_fire_b", ifb.press, 1);

    // Freeze during HOLD: A goes IDLE, nothing fires while frozen
    step();
    chk("after_press_a", ifa.press, 0);
    frz = 1'b1; lf = 10'd0;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      cnt_a += int'(ifa.press); cnt_b += int'(ifb.press);
    end
    chk("frozen_no_press_a", cnt_a, 0);
    chk("frozen_no_press_b", cnt_b, 0);
    frz = 1'b0;
    step();
    chk("unfreeze_press_a", ifa.press, 1);
    chk("unfreeze_press_b", ifb.press, 1);

    // Async reset while press is high clears it before the next edge
    #2 reset = 1'b1;
    #1;
    chk("async_reset_a", ifa.press, 0);
    chk("async_reset_b", ifb.press, 0);
    lvl = 10'd1023; lf = 10'd0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_reset_press_a", ifa.press, 1);

    // Saturating counter on B (always-fire, HOLDOFF 0)
`ifdef CPU_PLAYER_COUNT_EN
    chk("count_k1_b", ifb.press_count, 0);
    for (int k = 2; k <= 600; k++) begin
      step();
      if (k == 10)  chk("count_k10_b", ifb.press_count, 5);
      if (k == 510) chk("count_k510_b", ifb.press_count, 255);
      if (k == 600) chk("count_sat_b", ifb.press_count, 255);
    end
    frz = 1'b1; step(); frz = 1'b0; step();
    chk("count_after_freeze_b", ifb.press_count, 255);
    #2 reset = 1'b1;
    #1;
    chk("count_reset_b", ifb.press_count, 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    // enable low blocks new presses
    en = 1'b0;
    for (int k = 0; k < 6; k++) step();
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      cnt_a += int'(ifa.press); cnt_b += int'(ifb.press);
    end
    chk("disabled_a", cnt_a, 0);
    chk("disabled_b", cnt_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Downstream consumer of the 10-bit pseudo-random LFSR in the tug-of-war game.
- Compares each LFSR sample against a difficulty level set on the board switches.
- Turns a successful comparison into a single-cycle "button press" pulse for the computer-controlled player.
- Enforces a hold-off gap so presses cannot repeat every cycle; its output feeds the same edge-to-move path as the human player's key.

Parameters:
- WIDTH, 10, width of the LFSR sample and of the level compare.
- HOLDOFF_CYCLES, 3, idle cycles forced after each press before the next press may fire (0 is legal).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  game running; no new press fires when low
- freeze  input  1  game over / round won; aborts activity and blocks presses
- level  input  WIDTH  difficulty threshold from switches, unsigned; upper unused switches tied 0 at top level
- lfsr  input  WIDTH  current LFSR output, sampled every cycle
- press  output  1  registered one-cycle press pulse to the playfield logic
- press_count  output  8  saturating press counter (present only with CPU_PLAYER_COUNT_EN)

Behaviour:
- Reset (async, active-high): state=IDLE, hold counter=0, press=0, press_count=0. Reset mid-PRESS or mid-HOLD aborts immediately; press drops asynchronously.
- States: IDLE, PRESS, HOLD. press is high exactly when state==PRESS, with no combinational path from inputs.
- Fire condition, evaluated in IDLE only: enable && !freeze && (level > lfsr). The compare is unsigned and strict over the full WIDTH; equality does not fire.
- IDLE -> PRESS on fire, so press is high in the cycle after the qualifying sample (latency 1).
- PRESS -> HOLD with the counter loaded to HOLDOFF_CYCLES. If HOLDOFF_CYCLES==0, PRESS -> IDLE directly.
- HOLD: the counter decrements each cycle and the block goes to IDLE on the cycle the counter reaches 0 (HOLDOFF_CYCLES cycles in HOLD).
- Minimum press spacing is HOLDOFF_CYCLES+2 cycles, rising edge to rising edge.
- freeze high: next state is IDLE from any state and the counter clears. A PRESS already registered still lasts its single cycle; no pulse is ever truncated or stretched.
- freeze and fire in the same cycle: freeze wins and no press is issued.
- enable low: no new fire. An in-progress PRESS/HOLD completes normally.
- level==0: never fires.
- level==2^WIDTH-1: fires whenever lfsr is not all-ones. The XNOR LFSR never reaches all-ones in operation, so this is an always-fire setting, rate-limited only by the hold-off.
- The lfsr value is consumed as-is; no assumptions are made about its sequence.

Optional Feature:
- Macro: CPU_PLAYER_COUNT_EN.
- Defined: press_count port exists; it increments on each PRESS cycle and saturates at 255. It clears only on reset, not on freeze.
- Not defined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package cpu_player_pkg:
  - state enum typedef (IDLE, PRESS, HOLD), 2 bits
  - localparam CNT_W = 8 for press_count
  - hold counter width derived with $clog2(HOLDOFF_CYCLES+1), minimum 1
- No sub-module: the FSM, counter and compare fit in one module. The LFSR remains a separate sibling instance wired in at top level.

Test Plan:
- Default params, enable=1, freeze=0, level=1023, lfsr held 0 -> press high in cycles 1, 6, 11, 16 after release of reset (spacing 5 = HOLDOFF+2), each 1 cycle wide.
- level=0, lfsr swept 0..1022 over 1023 cycles -> press never asserts.
- level=100, lfsr=100 held -> no press; lfsr changes to 99 -> press high exactly one cycle later.
- Fire at cycle t, freeze=1 at t+2 (in HOLD) -> IDLE at t+3; with freeze still high and lfsr=0, no further press; freeze low at t+10 -> press at t+11.
- Assert reset asynchronously mid-cycle while press=1 -> press and state clear before the next clk edge. Release reset, level=1023, lfsr=0 -> first press 1 cycle after the first post-reset edge.
- With CPU_PLAYER_COUNT_EN, HOLDOFF_CYCLES=0, always-fire stimulus for 600 cycles -> press_count rises by 1 every 2 cycles, reaches 255, stays 255; freeze pulse does not clear it; reset does.
